// File: rtl/mux_sel_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer_if
//
// Purpose: bundles the load handshake, the held word / mux select outputs and
// the serial-bit handshake of mux_sel_sequencer into one interface.
//
// Parameters:
//   N     word width and mux input count (power of 2, >= 2)
//   SELW  derived select width, $clog2(N)
//
// Signals:
//   load_valid  upstream offers data_in
//   load_ready  sequencer can accept a word this cycle
//   data_in     parallel word to serialise
//   x_out       held word, drives the mux data inputs
//   ss          mux select
//   bit_valid   mux output holds a valid serial bit
//   bit_ready   downstream consumes the current bit
//   last        current beat is the final bit of the word
//   word_cnt    completed words, modulo 256
//
// Modports:
//   slave   the sequencer side
//   master  the upstream/downstream side (driver of load_valid, data_in, bit_ready)
// -----------------------------------------------------------------------------
interface mux_sel_sequencer_if #(
  parameter int N = 8
);
  localparam int SELW = $clog2(N);

  logic            load_valid;
  logic            load_ready;
  logic [N-1:0]    data_in;
  logic [N-1:0]    x_out;
  logic [SELW-1:0] ss;
  logic            bit_valid;
  logic            bit_ready;
  logic            last;
  logic [7:0]      word_cnt;

  modport slave (
    input  load_valid,
    input  data_in,
    input  bit_ready,
    output load_ready,
    output x_out,
    output ss,
    output bit_valid,
    output last,
    output word_cnt
  );

  modport master (
    output load_valid,
    output data_in,
    output bit_ready,
    input  load_ready,
    input  x_out,
    input  ss,
    input  bit_valid,
    input  last,
    input  word_cnt
  );

endinterface

// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Purpose: sits upstream of an N-to-1 mux. Accepts an N-bit word over a
// valid/ready handshake, holds it on the mux data inputs and steps the mux
// select through all N positions, one position per accepted downstream beat,
// so the mux output becomes a serial bit stream. Flags the last bit of each
// word and counts completed words.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    mux_sel_sequencer_if.slave (load handshake, x_out, ss, bit
//          handshake, last, word_cnt)
//
// Parameters:
//   N  word width / mux input count; must be a power of 2 and >= 2, and must
//      match the N of the connected interface instance.
//
// Build option:
//   MUX_SEL_SEQUENCER_MSB_FIRST_EN  defined: select counts N-1 down to 0 (MSB
//                                   first). Undefined: 0 up to N-1 (LSB first).
//
// States:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no word held; load_ready=1, bit_valid=0
//   ST_SHIFT | word held; bit_valid=1, ss selects the current bit
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mux_sel_sequencer_if.slave   bus
);

  localparam int SELW = $clog2(N);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

`ifdef MUX_SEL_SEQUENCER_MSB_FIRST_EN
  localparam logic [SELW-1:0] SS_START = SELW'(N - 1);
  localparam logic [SELW-1:0] SS_END   = '0;
`else
  localparam logic [SELW-1:0] SS_START = '0;
  localparam logic [SELW-1:0] SS_END   = SELW'(N - 1);
`endif

  logic [0:0]      state_q, state_d;
  logic [N-1:0]    x_q, x_d;
  logic [SELW-1:0] ss_q, ss_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            in_shift;
  logic            at_end;
  logic [SELW-1:0] ss_step;
  logic            load_ready;

  assign in_shift = (state_q == ST_SHIFT);
  assign at_end   = (ss_q == SS_END);

`ifdef MUX_SEL_SEQUENCER_MSB_FIRST_EN
  assign ss_step = ss_q - SELW'(1);
`else
  assign ss_step = ss_q + SELW'(1);
`endif

  // The only input-to-output combinational path: a new word may be taken in
  // the same cycle the final bit of the current word is consumed.
  always_comb begin
    load_ready = 1'b1;
    if (in_shift) begin
      load_ready = at_end & bus.bit_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ss_d    = ss_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          x_d     = bus.data_in;
          ss_d    = SS_START;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.bit_ready) begin
          if (!at_end) begin
            ss_d = ss_step;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (bus.load_valid) begin
              // Gapless reload: the next word's first bit follows directly.
              x_d  = bus.data_in;
              ss_d = SS_START;
            end else begin
              // ss deliberately left at SS_END while idle.
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      ss_q    <= SS_START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ss_q    <= ss_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.x_out      = x_q;
  assign bus.ss         = ss_q;
  assign bus.bit_valid  = in_shift;
  assign bus.last       = in_shift & at_end;
  assign bus.word_cnt   = cnt_q;

  // A stalled beat must leave the presented bit untouched.
  a_hold_on_stall : assert property (@(posedge clk) disable iff (reset)
    (in_shift && !bus.bit_ready) |=> (ss_q == $past(ss_q) && x_q == $past(x_q)));

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.N(N)) sif ();
  mux_sel_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  mux_sel_sequencer_if #(.N(2)) sif2 ();
  mux_sel_sequencer #(.N(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (sif2.slave)
  );

  // external muxN models
  logic mux_bit, mux_bit2;
  assign mux_bit  = sif.x_out[sif.ss];
  assign mux_bit2 = sif2.x_out[sif2.ss];

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // select value expected on beat i of an n-bit word
  function automatic int ss_at(input int i, input int n);
`ifdef MUX_SEL_SEQUENCER_MSB_FIRST_EN
    return n - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic check_beat(input string tag, input logic [7:0] w, input int i);
    int s;
    s = ss_at(i, N);
    chk({tag, "_ss"},   32'(sif.ss), 32'(s));
    chk({tag, "_bv"},   32'(sif.bit_valid), 32'd1);
    chk({tag, "_last"}, 32'(sif.last), (i == N - 1) ? 32'd1 : 32'd0);
    chk({tag, "_lr"},   32'(sif.load_ready), ((i == N - 1) && sif.bit_ready) ? 32'd1 : 32'd0);
    chk({tag, "_x"},    32'(sif.x_out), 32'(w));
    chk({tag, "_bit"},  32'(mux_bit), 32'(w[s]));
  endtask

  // load w from idle; optionally stall stall_n cycles before beat stall_idx
  task automatic send_word(input string tag, input logic [7:0] w, input int stall_idx, input int stall_n);
    @(negedge clk);
    sif.data_in = w; sif.load_valid = 1'b1; sif.bit_ready = 1'b1;
    #1;
    chk({tag, "_idle_lr"}, 32'(sif.load_ready), 32'd1);
    chk({tag, "_idle_bv"}, 32'(sif.bit_valid), 32'd0);
    @(negedge clk);
    sif.load_valid = 1'b0;
    sif.data_in = ~w;
    for (int i = 0; i < N; i++) begin
      if (i == stall_idx) begin
        for (int k = 0; k < stall_n; k++) begin
          sif.bit_ready = 1'b0;
          #1;
          chk({tag, "_stall_ss"}, 32'(sif.ss), 32'(ss_at(i, N)));
          chk({tag, "_stall_bv"}, 32'(sif.bit_valid), 32'd1);
          chk({tag, "_stall_lr"}, 32'(sif.load_ready), 32'd0);
          chk({tag, "_stall_bit"}, 32'(mux_bit), 32'(w[ss_at(i, N)]));
          @(negedge clk);
        end
      end
      sif.bit_ready = 1'b1;
      #1;
      check_beat(tag, w, i);
      @(negedge clk);
    end
    exp_cnt = (exp_cnt + 1) % 256;
    #1;
    chk({tag, "_end_bv"}, 32'(sif.bit_valid), 32'd0);
    chk({tag, "_end_lr"}, 32'(sif.load_ready), 32'd1);
    chk({tag, "_end_last"}, 32'(sif.last), 32'd0);
    chk({tag, "_end_ss"}, 32'(sif.ss), 32'(ss_at(N - 1, N)));
    chk({tag, "_end_cnt"}, 32'(sif.word_cnt), 32'(exp_cnt));
  endtask

  task automatic fast_word(input logic [7:0] w);
    @(negedge clk);
    sif.data_in = w; sif.load_valid = 1'b1; sif.bit_ready = 1'b1;
    @(negedge clk);
    sif.load_valid = 1'b0;
    repeat (N) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sif.load_valid = 1'b0; sif.data_in = '0; sif.bit_ready = 1'b0;
    sif2.load_valid = 1'b0; sif2.data_in = '0; sif2.bit_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_lr",   32'(sif.load_ready), 32'd1);
    chk("rst_bv",   32'(sif.bit_valid), 32'd0);
    chk("rst_last", 32'(sif.last), 32'd0);
    chk("rst_cnt",  32'(sif.word_cnt), 32'd0);
    chk("rst_x",    32'(sif.x_out), 32'd0);
    chk("rst_ss",   32'(sif.ss), 32'(ss_at(0, N)));

    // mid-word asynchronous reset at ss=5
    begin
      int b;
      b = (ss_at(0, N) == 0) ? 5 : 2;
      @(negedge clk);
      sif.data_in = 8'h55; sif.load_valid = 1'b1; sif.bit_ready = 1'b1;
      @(negedge clk);
      sif.load_valid = 1'b0;
      for (int i = 0; i < b; i++) begin
        #1;
        check_beat("mid", 8'h55, i);
        @(negedge clk);
      end
      #1;
      chk("mid_pre_ss", 32'(sif.ss), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_bv",  32'(sif.bit_valid), 32'd0);
      chk("mid_rst_lr",  32'(sif.load_ready), 32'd1);
      chk("mid_rst_ss",  32'(sif.ss), 32'(ss_at(0, N)));
      chk("mid_rst_cnt", 32'(sif.word_cnt), 32'd0);
      chk("mid_rst_x",   32'(sif.x_out), 32'd0);
      chk("mid_rst_last", 32'(sif.last), 32'd0);
      @(negedge clk);
      reset = 1'b0;
    end

    // single word after the aborted one, then with backpressure at ss=3
    send_word("single", 8'b0101_0101, -1, 0);
    send_word("bp", 8'b0101_0101, (ss_at(0, N) == 0) ? 3 : 4, 3);
    send_word("single2", 8'hC6, -1, 0);

    // back-to-back A5 then 3C with load_valid held high
    @(negedge clk);
    sif.data_in = 8'hA5; sif.load_valid = 1'b1; sif.bit_ready = 1'b1;
    @(negedge clk);
    sif.data_in = 8'h3C;
    for (int b = 0; b < 2 * N; b++) begin
      if (b == 2 * N - 1) sif.load_valid = 1'b0;
      #1;
      check_beat((b < N) ? "b2b_a5" : "b2b_3c", (b < N) ? 8'hA5 : 8'h3C, b % N);
      if (b == N) chk("b2b_mid_cnt", 32'(sif.word_cnt), 32'((exp_cnt + 1) % 256));
      @(negedge clk);
    end
    exp_cnt = (exp_cnt + 2) % 256;
    #1;
    chk("b2b_end_bv",  32'(sif.bit_valid), 32'd0);
    chk("b2b_end_cnt", 32'(sif.word_cnt), 32'(exp_cnt));

    // word counter wrap
    while (exp_cnt != 255) fast_word(8'h0F);
    #1;
    chk("wrap_255", 32'(sif.word_cnt), 32'd255);
    fast_word(8'hF0);
    #1;
    chk("wrap_0", 32'(sif.word_cnt), 32'd0);
    send_word("post_wrap", 8'h81, -1, 0);

    // N=2 boundary
    @(negedge clk);
    sif2.data_in = 2'b10; sif2.load_valid = 1'b1; sif2.bit_ready = 1'b1;
    #1;
    chk("n2_idle_lr", 32'(sif2.load_ready), 32'd1);
    @(negedge clk);
    sif2.load_valid = 1'b0;
    #1;
    chk("n2_b0_ss",   32'(sif2.ss), 32'(ss_at(0, 2)));
    chk("n2_b0_bv",   32'(sif2.bit_valid), 32'd1);
    chk("n2_b0_last", 32'(sif2.last), 32'd0);
    chk("n2_b0_bit",  32'(mux_bit2), (ss_at(0, 2) == 1) ? 32'd1 : 32'd0);
    @(negedge clk);
    #1;
    chk("n2_b1_ss",   32'(sif2.ss), 32'(ss_at(1, 2)));
    chk("n2_b1_last", 32'(sif2.last), 32'd1);
    chk("n2_b1_lr",   32'(sif2.load_ready), 32'd1);
    chk("n2_b1_bit",  32'(mux_bit2), (ss_at(1, 2) == 1) ? 32'd1 : 32'd0);
    @(negedge clk);
    #1;
    chk("n2_end_bv",  32'(sif2.bit_valid), 32'd0);
    chk("n2_end_cnt", 32'(sif2.word_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
